// File: rtl/o_feature_store_pkg.sv
// Shared defaults, FSM state encoding and lane helper for the output feature store.
package o_feature_store_pkg;

    localparam int unsigned FEATURE_WIDTH_DEF  = 16;
    localparam int unsigned DATA_BUS_WIDTH_DEF = 128;
    localparam int unsigned ADDR_WIDTH_DEF     = 16;
    localparam int unsigned CNT_WIDTH_DEF      = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPack  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } store_state_e;

    function automatic int unsigned lanes(int unsigned feature_width, int unsigned bus_width);
        return bus_width / feature_width;
    endfunction

endpackage

// File: rtl/o_feature_packer.sv
// Packs accepted features into a bus word, lane 0 first, and holds the completed word
// (with its word_full flag) until the write is taken.
module o_feature_packer
    import o_feature_store_pkg::*;
#(
    parameter int unsigned FEATURE_WIDTH  = FEATURE_WIDTH_DEF,
    parameter int unsigned DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [FEATURE_WIDTH-1:0]  feature,
    input  logic                      word_taken,
    output logic                      last_accept,
    output logic                      word_full,
    output logic [DATA_BUS_WIDTH-1:0] word
);

    localparam int unsigned LANES  = lanes(FEATURE_WIDTH, DATA_BUS_WIDTH);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]         lane_q;
    logic [DATA_BUS_WIDTH-1:0] pack_q;
    logic [DATA_BUS_WIDTH-1:0] pack_d;

    assign last_accept = accept && (lane_q == LAST_LANE);

    always_comb begin
        pack_d = pack_q;
        pack_d[int'(lane_q) * FEATURE_WIDTH +: FEATURE_WIDTH] = feature;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            pack_q    <= '0;
            word_full <= 1'b0;
            word      <= '0;
        end else if (clear) begin
            lane_q    <= '0;
            word_full <= 1'b0;
        end else begin
            if (accept) begin
                pack_q <= pack_d;
                if (last_accept) begin
                    // Snapshot the finished word so the bus stays stable while the next one packs.
                    lane_q    <= '0;
                    word      <= pack_d;
                    word_full <= 1'b1;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
            if (word_taken) begin
                word_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/o_feature_store.sv
// Drains adder-tree output features to external memory: packs LANES features per bus word
// and writes words to consecutive addresses, pulsing store_done when finished.
module o_feature_store
    import o_feature_store_pkg::*;
#(
    parameter int unsigned FEATURE_WIDTH  = FEATURE_WIDTH_DEF,
    parameter int unsigned DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_enable,
    input  logic [ADDR_WIDTH-1:0]     dst_addr,
    input  logic [CNT_WIDTH-1:0]      store_count,
    input  logic [FEATURE_WIDTH-1:0]  feature_in,
    input  logic                      feature_valid,
    output logic                      feature_ready,
    output logic [DATA_BUS_WIDTH-1:0] o_data_bus_port,
    output logic [ADDR_WIDTH-1:0]     o_feature_addr,
    output logic                      o_feature_wr_en,
    input  logic                      o_wr_ready,
    output logic                      busy,
    output logic                      store_done
);

    store_state_e         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  left_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  start;
    logic                  accept;
    logic                  last_accept;
    logic                  wr_accept;

    assign feature_ready  = (state_q == StPack);
    assign accept         = feature_valid && feature_ready;
    assign wr_accept      = o_feature_wr_en && o_wr_ready;
    assign start          = store_enable && (state_q == StIdle);
    assign o_feature_addr = addr_q;
    assign busy           = busy_q;
    assign store_done     = done_q;

    o_feature_packer #(
        .FEATURE_WIDTH  (FEATURE_WIDTH),
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (start),
        .accept      (accept),
        .feature     (feature_in),
        .word_taken  (wr_accept),
        .last_accept (last_accept),
        .word_full   (o_feature_wr_en),
        .word        (o_data_bus_port)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (store_enable) begin
                        addr_q <= dst_addr;
                        left_q <= store_count;
                        busy_q <= 1'b1;
                        if (store_count == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StPack;
                        end
                    end
                end
                StPack: begin
                    if (last_accept) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (wr_accept) begin
                        addr_q <= addr_q + 1'b1;
                        left_q <= left_q - 1'b1;
                        if (left_q == CNT_WIDTH'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StPack;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_o_feature_store.sv
// Directed self-checking bench for o_feature_store with hand-computed expected values.
module tb_o_feature_store;

    logic         clk = 1'b0;
    logic         rst;
    logic         store_enable;
    logic [15:0]  dst_addr;
    logic [7:0]   store_count;
    logic [15:0]  feature_in;
    logic         feature_valid;
    logic         feature_ready;
    logic [127:0] o_data_bus_port;
    logic [15:0]  o_feature_addr;
    logic         o_feature_wr_en;
    logic         o_wr_ready;
    logic         busy;
    logic         store_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    o_feature_store dut (
        .clk             (clk),
        .rst             (rst),
        .store_enable    (store_enable),
        .dst_addr        (dst_addr),
        .store_count     (store_count),
        .feature_in      (feature_in),
        .feature_valid   (feature_valid),
        .feature_ready   (feature_ready),
        .o_data_bus_port (o_data_bus_port),
        .o_feature_addr  (o_feature_addr),
        .o_feature_wr_en (o_feature_wr_en),
        .o_wr_ready      (o_wr_ready),
        .busy            (busy),
        .store_done      (store_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] packed_word(input logic [15:0] base);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = base + 16'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] addr, input logic [7:0] cnt);
        store_enable = 1'b1;
        dst_addr     = addr;
        store_count  = cnt;
        tick();
        store_enable = 1'b0;
    endtask

    // Feeds eight features base..base+7; optional idle gaps and a store_enable poke while busy.
    task automatic feed(input logic [15:0] base, input bit gaps, input bit poke, input string tag);
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                feature_valid = 1'b0;
                feature_in    = 16'hDEAD;
                chk({tag, "_ready_gap"}, 128'(feature_ready), 128'(1));
                tick();
            end
            feature_valid = 1'b1;
            feature_in    = base + 16'(k);
            if (poke && k == 0) begin
                store_enable = 1'b1;
                dst_addr     = 16'h0777;
                store_count  = 8'd5;
            end
            chk({tag, "_ready"}, 128'(feature_ready), 128'(1));
            chk({tag, "_wren_lo"}, 128'(o_feature_wr_en), 128'(0));
            tick();
            store_enable = 1'b0;
        end
        feature_valid = 1'b0;
        feature_in    = 16'h0000;
    endtask

    task automatic expect_write(input logic [15:0] addr, input logic [15:0] base,
                                input string tag);
        chk({tag, "_wren"}, 128'(o_feature_wr_en), 128'(1));
        chk({tag, "_addr"}, 128'(o_feature_addr), 128'(addr));
        chk({tag, "_data"}, o_data_bus_port, packed_word(base));
        chk({tag, "_ready_lo"}, 128'(feature_ready), 128'(0));
        chk({tag, "_nodone"}, 128'(store_done), 128'(0));
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 128'(store_done), 128'(1));
        chk({tag, "_done_wren"}, 128'(o_feature_wr_en), 128'(0));
        tick();
        chk({tag, "_done_lo"}, 128'(store_done), 128'(0));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    initial begin
        rst           = 1'b1;
        store_enable  = 1'b0;
        dst_addr      = '0;
        store_count   = '0;
        feature_in    = '0;
        feature_valid = 1'b0;
        o_wr_ready    = 1'b1;
        #12;
        chk("rst_wren", 128'(o_feature_wr_en), 128'(0));
        chk("rst_data", o_data_bus_port, 128'(0));
        chk("rst_addr", 128'(o_feature_addr), 128'(0));
        chk("rst_busy_ready_done", 128'({busy, feature_ready, store_done}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: single word
        start(16'h0100, 8'd1);
        chk("t1_busy", 128'(busy), 128'(1));
        feed(16'd1, 1'b0, 1'b0, "t1");
        expect_write(16'h0100, 16'd1, "t1");
        tick();
        expect_done("t1");

        // 2: three words back to back
        start(16'h0100, 8'd3);
        for (int w = 0; w < 3; w++) begin
            feed(16'(9 + 8 * w), 1'b0, 1'b0, "t2");
            expect_write(16'h0100 + 16'(w), 16'(9 + 8 * w), "t2");
            tick();
            if (w < 2) chk("t2_mid_nodone", 128'(store_done), 128'(0));
        end
        expect_done("t2");

        // 3: valid toggling
        start(16'h0100, 8'd1);
        feed(16'd1, 1'b1, 1'b0, "t3");
        expect_write(16'h0100, 16'd1, "t3");
        tick();
        expect_done("t3");

        // 4: write back-pressure for 5 cycles with junk features offered
        o_wr_ready = 1'b0;
        start(16'h0040, 8'd2);
        feed(16'h0031, 1'b0, 1'b0, "t4");
        feature_valid = 1'b1;
        feature_in    = 16'h0BAD;
        for (int s = 0; s < 5; s++) begin
            expect_write(16'h0040, 16'h0031, "t4_stall");
            tick();
        end
        expect_write(16'h0040, 16'h0031, "t4_stall_end");
        o_wr_ready    = 1'b1;
        feature_valid = 1'b0;
        tick();
        chk("t4_back_to_pack", 128'(feature_ready), 128'(1));
        feed(16'h0041, 1'b0, 1'b0, "t4b");
        expect_write(16'h0041, 16'h0041, "t4b");
        tick();
        expect_done("t4");

        // 5: address wrap, then zero count
        start(16'hFFFF, 8'd2);
        feed(16'h0051, 1'b0, 1'b0, "t5a");
        expect_write(16'hFFFF, 16'h0051, "t5a");
        tick();
        feed(16'h0061, 1'b0, 1'b0, "t5b");
        expect_write(16'h0000, 16'h0061, "t5b");
        tick();
        expect_done("t5");
        start(16'h1234, 8'd0);
        chk("t5_zero_ready", 128'(feature_ready), 128'(0));
        expect_done("t5_zero");

        // 6: reset mid-pack, restart, store_enable while busy is ignored
        start(16'h0300, 8'd1);
        feature_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            feature_in = 16'h0071 + 16'(k);
            tick();
        end
        feature_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", 128'({busy, feature_ready, store_done, o_feature_wr_en}), 128'(0));
        chk("t6_rst_addr", 128'(o_feature_addr), 128'(0));
        chk("t6_rst_data", o_data_bus_port, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_no_done", 128'(store_done), 128'(0));
        start(16'h0200, 8'd1);
        feed(16'h0021, 1'b0, 1'b1, "t6");
        expect_write(16'h0200, 16'h0021, "t6");
        tick();
        expect_done("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
